fpnew_issue_seq: RTL and testbench

// - Core-side initiator for the FPU's valid/ready request/response protocol.
// - Forwards core FP requests to the FPU and stamps each one with a rotating tag.
// - The FPU arbitrates between opgroups, so results can return out of order. This block collects them in a
//   2**TAG_WIDTH-entry reorder buffer (ROB) and retires them to the core strictly in issue order.
// - Also accumulates sticky IEEE flags and reports protocol violations.

---
 rtl/fpnew_pkg.sv | 52 +++++
 rtl/fpnew_issue_rob.sv | 80 ++++++++
 rtl/fpnew_issue_seq.sv | 165 ++++++++++++++++
 tb/tb_fpnew_issue_seq.sv | 359 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpnew_pkg.sv
// Shared FPU types plus the reorder-buffer entry used by the core-side issue sequencer.
package fpnew_pkg;

   localparam int unsigned ROB_RESULT_WIDTH = 32;
   localparam int unsigned ROB_RD_WIDTH     = 5;

   typedef enum logic [2:0] {
      RNE = 3'b000,
      RTZ = 3'b001,
      RDN = 3'b010,
      RUP = 3'b011,
      RMM = 3'b100,
      ROD = 3'b101,
      DYN = 3'b111
   } roundmode_e;

   typedef enum logic [3:0] {
      FMADD, FNMSUB, ADD, MUL, DIV, SQRT, SGNJ, MINMAX,
      CMP, CLASSIFY, F2F, F2I, I2F, CPKAB, CPKCD
   } operation_e;

   typedef enum logic [2:0] {
      FP32    = 3'd0,
      FP64    = 3'd1,
      FP16    = 3'd2,
      FP8     = 3'd3,
      FP16ALT = 3'd4
   } fp_format_e;

   typedef enum logic [1:0] {
      INT8, INT16, INT32, INT64
   } int_format_e;

   typedef struct packed {
      logic NV;
      logic DZ;
      logic OF;
      logic UF;
      logic NX;
   } status_t;

   typedef struct packed {
      logic [ROB_RESULT_WIDTH-1:0] result;
      status_t                     status;
      logic [ROB_RD_WIDTH-1:0]     rd;
   } rob_entry_t;

   function automatic status_t or_status(input status_t a, input status_t b);
      return status_t'(5'(a) | 5'(b));
   endfunction

endpackage

// File: rtl/fpnew_issue_rob.sv
// Reorder buffer: allocated at issue, written by returning tag, read and retired at the head.
module fpnew_issue_rob
   import fpnew_pkg::*;
#(
   parameter int unsigned TAG_WIDTH = 1,
   parameter int unsigned WIDTH     = 32,
   parameter int unsigned RD_WIDTH  = 5
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 clear_i,
   input  logic                 alloc_i,
   input  logic [TAG_WIDTH-1:0] alloc_tag_i,
   input  logic [RD_WIDTH-1:0]  alloc_rd_i,
   input  logic                 wr_i,
   input  logic [TAG_WIDTH-1:0] wr_tag_i,
   input  logic [WIDTH-1:0]     wr_result_i,
   input  status_t              wr_status_i,
   input  logic                 retire_i,
   input  logic [TAG_WIDTH-1:0] head_tag_i,
   output logic                 wr_ok_o,
   output logic                 head_done_o,
   output logic [WIDTH-1:0]     head_result_o,
   output status_t              head_status_o,
   output logic [RD_WIDTH-1:0]  head_rd_o
);

   localparam int unsigned DEPTH = 2 ** TAG_WIDTH;

   logic [DEPTH-1:0] r_alloc;
   logic [DEPTH-1:0] r_done;
   logic [DEPTH-1:0] w_alloc_nxt;
   logic [DEPTH-1:0] w_done_nxt;
   rob_entry_t       r_entry [DEPTH];

   // A result is only legal for an allocated entry that has not completed yet
   assign wr_ok_o = r_alloc[wr_tag_i] & ~r_done[wr_tag_i];

   assign head_done_o   = r_done[head_tag_i];
   assign head_result_o = WIDTH'(r_entry[head_tag_i].result);
   assign head_status_o = r_entry[head_tag_i].status;
   assign head_rd_o     = RD_WIDTH'(r_entry[head_tag_i].rd);

   always_comb begin
      w_alloc_nxt = r_alloc;
      w_done_nxt  = r_done;
      if (retire_i) begin
         w_alloc_nxt[head_tag_i] = 1'b0;
         w_done_nxt[head_tag_i]  = 1'b0;
      end
      if (alloc_i) begin
         w_alloc_nxt[alloc_tag_i] = 1'b1;
      end
      if (wr_i) begin
         w_done_nxt[wr_tag_i] = 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni || clear_i) begin
         r_alloc <= '0;
         r_done  <= '0;
      end else begin
         r_alloc <= w_alloc_nxt;
         r_done  <= w_done_nxt;
      end
   end

   // Payload needs no reset: it is only observed through the done bits
   always_ff @(posedge clk_i) begin
      if (alloc_i) begin
         r_entry[alloc_tag_i].rd <= ROB_RD_WIDTH'(alloc_rd_i);
      end
      if (wr_i) begin
         r_entry[wr_tag_i].result <= ROB_RESULT_WIDTH'(wr_result_i);
         r_entry[wr_tag_i].status <= wr_status_i;
      end
   end

endmodule

// File: rtl/fpnew_issue_seq.sv
// Core-side FPU initiator: tags issued ops, reorders out-of-order results, retires in issue order.
module fpnew_issue_seq
   import fpnew_pkg::*;
#(
   parameter int unsigned WIDTH     = 32,
   parameter int unsigned TAG_WIDTH = 1,
   parameter int unsigned RD_WIDTH  = 5
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   input  logic                   req_valid_i,
   output logic                   req_ready_o,
   input  logic [3*WIDTH-1:0]     req_operands_i,
   input  roundmode_e             req_rnd_mode_i,
   input  operation_e             req_op_i,
   input  logic                   req_op_mod_i,
   input  logic                   req_vectorial_op_i,
   input  fp_format_e             req_src_fmt_i,
   input  fp_format_e             req_dst_fmt_i,
   input  int_format_e            req_int_fmt_i,
   input  logic [RD_WIDTH-1:0]    req_rd_i,
   output logic [3*WIDTH-1:0]     fpu_operands_o,
   output roundmode_e             fpu_rnd_mode_o,
   output operation_e             fpu_op_o,
   output logic                   fpu_op_mod_o,
   output logic                   fpu_vectorial_op_o,
   output fp_format_e             fpu_src_fmt_o,
   output fp_format_e             fpu_dst_fmt_o,
   output int_format_e            fpu_int_fmt_o,
   output logic [TAG_WIDTH-1:0]   fpu_tag_o,
   output logic                   fpu_in_valid_o,
   input  logic                   fpu_in_ready_i,
   output logic                   fpu_flush_o,
   input  logic                   fpu_out_valid_i,
   output logic                   fpu_out_ready_o,
   input  logic [WIDTH-1:0]       fpu_result_i,
   input  status_t                fpu_status_i,
   input  logic [TAG_WIDTH-1:0]   fpu_tag_i,
   output logic                   rsp_valid_o,
   input  logic                   rsp_ready_i,
   output logic [WIDTH-1:0]       rsp_result_o,
   output status_t                rsp_status_o,
   output logic [RD_WIDTH-1:0]    rsp_rd_o,
   input  logic                   flush_i,
   input  logic                   fflags_clr_i,
   output status_t                fflags_o,
   output logic                   busy_o,
   output logic                   protocol_err_o
);

   localparam int unsigned DEPTH     = 2 ** TAG_WIDTH;
   localparam int unsigned CNT_WIDTH = TAG_WIDTH + 1;

   logic [TAG_WIDTH-1:0] r_wr_ptr;
   logic [TAG_WIDTH-1:0] r_rd_ptr;
   logic [CNT_WIDTH-1:0] r_count;
   logic [CNT_WIDTH-1:0] w_count_nxt;
   status_t              r_fflags;
   logic                 r_protocol_err;

   logic    w_full;
   logic    w_issue;
   logic    w_retire;
   logic    w_result_ok;
   logic    w_result_err;
   logic    w_wr_ok;
   logic    w_head_done;
   status_t w_head_status;

   assign fpu_operands_o     = req_operands_i;
   assign fpu_rnd_mode_o     = req_rnd_mode_i;
   assign fpu_op_o           = req_op_i;
   assign fpu_op_mod_o       = req_op_mod_i;
   assign fpu_vectorial_op_o = req_vectorial_op_i;
   assign fpu_src_fmt_o      = req_src_fmt_i;
   assign fpu_dst_fmt_o      = req_dst_fmt_i;
   assign fpu_int_fmt_o      = req_int_fmt_i;
   assign fpu_tag_o          = r_wr_ptr;
   assign fpu_flush_o        = flush_i;
   assign fpu_out_ready_o    = 1'b1;

   // Issue valid is built without fpu_in_ready_i so the FPU may derive ready from valid
   assign w_full         = (r_count == CNT_WIDTH'(DEPTH));
   assign fpu_in_valid_o = req_valid_i & ~w_full & ~flush_i;
   assign req_ready_o    = fpu_in_valid_o & fpu_in_ready_i;
   assign w_issue        = req_ready_o;

   assign w_result_ok  = fpu_out_valid_i & ~flush_i & w_wr_ok;
   assign w_result_err = fpu_out_valid_i & ~flush_i & ~w_wr_ok;

   assign rsp_valid_o  = w_head_done;
   assign rsp_status_o = w_head_status;
   assign w_retire     = w_head_done & rsp_ready_i & ~flush_i;

   assign fflags_o       = r_fflags;
   assign protocol_err_o = r_protocol_err;
   assign busy_o         = (r_count != '0);

   always_comb begin
      w_count_nxt = r_count;
      case ({w_issue, w_retire})
         2'b10:   w_count_nxt = r_count + CNT_WIDTH'(1);
         2'b01:   w_count_nxt = r_count - CNT_WIDTH'(1);
         default: w_count_nxt = r_count;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         r_wr_ptr       <= '0;
         r_rd_ptr       <= '0;
         r_count        <= '0;
         r_fflags       <= '0;
         r_protocol_err <= 1'b0;
      end else begin
         if (flush_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
         end else begin
            if (w_issue) begin
               r_wr_ptr <= r_wr_ptr + TAG_WIDTH'(1);
            end
            if (w_retire) begin
               r_rd_ptr <= r_rd_ptr + TAG_WIDTH'(1);
            end
            r_count <= w_count_nxt;
         end
         // Clear wins over a same-cycle retire
         if (fflags_clr_i) begin
            r_fflags <= '0;
         end else if (w_retire) begin
            r_fflags <= or_status(r_fflags, w_head_status);
         end
         if (w_result_err) begin
            r_protocol_err <= 1'b1;
         end
      end
   end

   fpnew_issue_rob #(
      .TAG_WIDTH (TAG_WIDTH),
      .WIDTH     (WIDTH),
      .RD_WIDTH  (RD_WIDTH)
   ) u_rob (
      .clk_i         (clk_i),
      .rst_ni        (rst_ni),
      .clear_i       (flush_i),
      .alloc_i       (w_issue),
      .alloc_tag_i   (r_wr_ptr),
      .alloc_rd_i    (req_rd_i),
      .wr_i          (w_result_ok),
      .wr_tag_i      (fpu_tag_i),
      .wr_result_i   (fpu_result_i),
      .wr_status_i   (fpu_status_i),
      .retire_i      (w_retire),
      .head_tag_i    (r_rd_ptr),
      .wr_ok_o       (w_wr_ok),
      .head_done_o   (w_head_done),
      .head_result_o (rsp_result_o),
      .head_status_o (w_head_status),
      .head_rd_o     (rsp_rd_o)
   );

endmodule

// File: tb/tb_fpnew_issue_seq.sv
// Directed bench for fpnew_issue_seq: ordering, reorder, full, backpressure, flush and flags.
module tb_fpnew_issue_seq;
   import fpnew_pkg::*;

   localparam int unsigned WIDTH     = 32;
   localparam int unsigned TAG_WIDTH = 1;
   localparam int unsigned RD_WIDTH  = 5;

   logic                 clk_i = 1'b0;
   logic                 rst_ni;
   logic                 req_valid_i;
   logic                 req_ready_o;
   logic [3*WIDTH-1:0]   req_operands_i;
   roundmode_e           req_rnd_mode_i;
   operation_e           req_op_i;
   logic                 req_op_mod_i;
   logic                 req_vectorial_op_i;
   fp_format_e           req_src_fmt_i;
   fp_format_e           req_dst_fmt_i;
   int_format_e          req_int_fmt_i;
   logic [RD_WIDTH-1:0]  req_rd_i;
   logic [3*WIDTH-1:0]   fpu_operands_o;
   roundmode_e           fpu_rnd_mode_o;
   operation_e           fpu_op_o;
   logic                 fpu_op_mod_o;
   logic                 fpu_vectorial_op_o;
   fp_format_e           fpu_src_fmt_o;
   fp_format_e           fpu_dst_fmt_o;
   int_format_e          fpu_int_fmt_o;
   logic [TAG_WIDTH-1:0] fpu_tag_o;
   logic                 fpu_in_valid_o;
   logic                 fpu_in_ready_i;
   logic                 fpu_flush_o;
   logic                 fpu_out_valid_i;
   logic                 fpu_out_ready_o;
   logic [WIDTH-1:0]     fpu_result_i;
   status_t              fpu_status_i;
   logic [TAG_WIDTH-1:0] fpu_tag_i;
   logic                 rsp_valid_o;
   logic                 rsp_ready_i;
   logic [WIDTH-1:0]     rsp_result_o;
   status_t              rsp_status_o;
   logic [RD_WIDTH-1:0]  rsp_rd_o;
   logic                 flush_i;
   logic                 fflags_clr_i;
   status_t              fflags_o;
   logic                 busy_o;
   logic                 protocol_err_o;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk_i = ~clk_i;

   fpnew_issue_seq #(
      .WIDTH     (WIDTH),
      .TAG_WIDTH (TAG_WIDTH),
      .RD_WIDTH  (RD_WIDTH)
   ) dut (
      .clk_i              (clk_i),
      .rst_ni             (rst_ni),
      .req_valid_i        (req_valid_i),
      .req_ready_o        (req_ready_o),
      .req_operands_i     (req_operands_i),
      .req_rnd_mode_i     (req_rnd_mode_i),
      .req_op_i           (req_op_i),
      .req_op_mod_i       (req_op_mod_i),
      .req_vectorial_op_i (req_vectorial_op_i),
      .req_src_fmt_i      (req_src_fmt_i),
      .req_dst_fmt_i      (req_dst_fmt_i),
      .req_int_fmt_i      (req_int_fmt_i),
      .req_rd_i           (req_rd_i),
      .fpu_operands_o     (fpu_operands_o),
      .fpu_rnd_mode_o     (fpu_rnd_mode_o),
      .fpu_op_o           (fpu_op_o),
      .fpu_op_mod_o       (fpu_op_mod_o),
      .fpu_vectorial_op_o (fpu_vectorial_op_o),
      .fpu_src_fmt_o      (fpu_src_fmt_o),
      .fpu_dst_fmt_o      (fpu_dst_fmt_o),
      .fpu_int_fmt_o      (fpu_int_fmt_o),
      .fpu_tag_o          (fpu_tag_o),
      .fpu_in_valid_o     (fpu_in_valid_o),
      .fpu_in_ready_i     (fpu_in_ready_i),
      .fpu_flush_o        (fpu_flush_o),
      .fpu_out_valid_i    (fpu_out_valid_i),
      .fpu_out_ready_o    (fpu_out_ready_o),
      .fpu_result_i       (fpu_result_i),
      .fpu_status_i       (fpu_status_i),
      .fpu_tag_i          (fpu_tag_i),
      .rsp_valid_o        (rsp_valid_o),
      .rsp_ready_i        (rsp_ready_i),
      .rsp_result_o       (rsp_result_o),
      .rsp_status_o       (rsp_status_o),
      .rsp_rd_o           (rsp_rd_o),
      .flush_i            (flush_i),
      .fflags_clr_i       (fflags_clr_i),
      .fflags_o           (fflags_o),
      .busy_o             (busy_o),
      .protocol_err_o     (protocol_err_o)
   );

   task automatic check_eq(input string tag, input logic [95:0] got, input logic [95:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic fpu_return(input logic [TAG_WIDTH-1:0] t, input logic [31:0] r, input logic [4:0] s);
      fpu_out_valid_i = 1'b1;
      fpu_tag_i       = t;
      fpu_result_i    = r;
      fpu_status_i    = status_t'(s);
   endtask

   initial begin
      rst_ni             = 1'b0;
      req_valid_i        = 1'b0;
      req_operands_i     = '0;
      req_rnd_mode_i     = RNE;
      req_op_i           = ADD;
      req_op_mod_i       = 1'b0;
      req_vectorial_op_i = 1'b0;
      req_src_fmt_i      = FP32;
      req_dst_fmt_i      = FP32;
      req_int_fmt_i      = INT32;
      req_rd_i           = '0;
      fpu_in_ready_i     = 1'b1;
      fpu_out_valid_i    = 1'b0;
      fpu_result_i       = '0;
      fpu_status_i       = '0;
      fpu_tag_i          = '0;
      rsp_ready_i        = 1'b0;
      flush_i            = 1'b0;
      fflags_clr_i       = 1'b0;
      tick();
      tick();
      check_eq("rst_busy", 96'(busy_o), 96'd0);
      check_eq("rst_rsp_valid", 96'(rsp_valid_o), 96'd0);
      check_eq("rst_perr", 96'(protocol_err_o), 96'd0);
      check_eq("rst_fflags", 96'(fflags_o), 96'd0);
      check_eq("out_ready", 96'(fpu_out_ready_o), 96'd1);
      rst_ni = 1'b1;

      // back-to-back in-order
      req_valid_i    = 1'b1;
      req_rd_i       = 5'd3;
      req_operands_i = 96'h0000_0001_4000_0000_3f80_0000;
      req_rnd_mode_i = RDN;
      #1;
      check_eq("b2b_in_valid0", 96'(fpu_in_valid_o), 96'd1);
      check_eq("b2b_ready0", 96'(req_ready_o), 96'd1);
      check_eq("b2b_tag0", 96'(fpu_tag_o), 96'd0);
      check_eq("fwd_operands", fpu_operands_o, 96'h0000_0001_4000_0000_3f80_0000);
      check_eq("fwd_rnd", 96'(fpu_rnd_mode_o), 96'(3'b010));
      tick();
      req_rd_i = 5'd7;
      #1;
      check_eq("b2b_tag1", 96'(fpu_tag_o), 96'd1);
      check_eq("b2b_ready1", 96'(req_ready_o), 96'd1);
      check_eq("b2b_busy", 96'(busy_o), 96'd1);
      tick();
      req_valid_i = 1'b0;
      fpu_return(1'b0, 32'h3f80_0000, 5'b0);
      #1;
      check_eq("b2b_no_bypass", 96'(rsp_valid_o), 96'd0);
      tick();
      fpu_return(1'b1, 32'h4000_0000, 5'b0);
      rsp_ready_i = 1'b1;
      #1;
      check_eq("b2b_rsp0_valid", 96'(rsp_valid_o), 96'd1);
      check_eq("b2b_rsp0_rd", 96'(rsp_rd_o), 96'd3);
      check_eq("b2b_rsp0_res", 96'(rsp_result_o), 96'h3f80_0000);
      tick();
      fpu_out_valid_i = 1'b0;
      #1;
      check_eq("b2b_rsp1_valid", 96'(rsp_valid_o), 96'd1);
      check_eq("b2b_rsp1_rd", 96'(rsp_rd_o), 96'd7);
      check_eq("b2b_rsp1_res", 96'(rsp_result_o), 96'h4000_0000);
      check_eq("b2b_busy_before", 96'(busy_o), 96'd1);
      tick();
      check_eq("b2b_busy_after", 96'(busy_o), 96'd0);
      check_eq("b2b_rsp_idle", 96'(rsp_valid_o), 96'd0);

      // out-of-order return
      req_valid_i = 1'b1;
      req_op_i    = DIV;
      req_rd_i    = 5'd0;
      #1;
      check_eq("ro_tag0", 96'(fpu_tag_o), 96'd0);
      tick();
      req_op_i = ADD;
      req_rd_i = 5'd1;
      #1;
      check_eq("ro_tag1", 96'(fpu_tag_o), 96'd1);
      tick();
      req_valid_i = 1'b0;
      fpu_return(1'b1, 32'h0000_bbbb, 5'b0);
      #1;
      tick();
      fpu_return(1'b0, 32'h0000_aaaa, 5'b0);
      #1;
      check_eq("ro_wait_head", 96'(rsp_valid_o), 96'd0);
      tick();
      fpu_out_valid_i = 1'b0;
      #1;
      check_eq("ro_rsp0_valid", 96'(rsp_valid_o), 96'd1);
      check_eq("ro_rsp0_rd", 96'(rsp_rd_o), 96'd0);
      check_eq("ro_rsp0_res", 96'(rsp_result_o), 96'h0000_aaaa);
      tick();
      check_eq("ro_rsp1_rd", 96'(rsp_rd_o), 96'd1);
      check_eq("ro_rsp1_res", 96'(rsp_result_o), 96'h0000_bbbb);
      tick();
      check_eq("ro_idle", 96'(rsp_valid_o), 96'd0);
      rsp_ready_i = 1'b0;

      // full, then backpressure with both entries done
      req_valid_i = 1'b1;
      req_rd_i    = 5'd10;
      #1;
      tick();
      req_rd_i = 5'd11;
      #1;
      tick();
      req_rd_i = 5'd12;
      #1;
      check_eq("full_in_valid", 96'(fpu_in_valid_o), 96'd0);
      check_eq("full_ready", 96'(req_ready_o), 96'd0);
      fpu_return(1'b0, 32'h0000_00c0, 5'b0);
      tick();
      fpu_return(1'b1, 32'h0000_00c1, 5'b0);
      tick();
      fpu_out_valid_i = 1'b0;
      #1;
      check_eq("bp_done_ready", 96'(req_ready_o), 96'd0);
      check_eq("bp_done_in_valid", 96'(fpu_in_valid_o), 96'd0);
      check_eq("bp_rd", 96'(rsp_rd_o), 96'd10);
      for (int i = 0; i < 5; i++) begin
         tick();
         check_eq("bp_hold_valid", 96'(rsp_valid_o), 96'd1);
         check_eq("bp_hold_res", 96'(rsp_result_o), 96'h0000_00c0);
      end
      rsp_ready_i = 1'b1;
      #1;
      check_eq("full_retire_cycle", 96'(req_ready_o), 96'd0);
      tick();
      check_eq("resume_in_valid", 96'(fpu_in_valid_o), 96'd1);
      check_eq("resume_tag", 96'(fpu_tag_o), 96'd0);
      check_eq("resume_ready", 96'(req_ready_o), 96'd1);
      check_eq("resume_rsp_rd", 96'(rsp_rd_o), 96'd11);
      tick();
      req_valid_i = 1'b0;
      #1;
      check_eq("swap_busy", 96'(busy_o), 96'd1);
      check_eq("swap_rsp_valid", 96'(rsp_valid_o), 96'd0);
      fpu_return(1'b0, 32'h0000_00c2, 5'b0);
      tick();
      fpu_out_valid_i = 1'b0;
      #1;
      check_eq("swap_rsp_rd", 96'(rsp_rd_o), 96'd12);
      check_eq("swap_rsp_res", 96'(rsp_result_o), 96'h0000_00c2);
      tick();
      check_eq("swap_idle", 96'(busy_o), 96'd0);
      rsp_ready_i = 1'b0;

      // flush with two outstanding and a same-cycle result
      req_valid_i = 1'b1;
      req_rd_i    = 5'd20;
      #1;
      check_eq("fl_tag_a", 96'(fpu_tag_o), 96'd1);
      tick();
      req_rd_i = 5'd21;
      #1;
      check_eq("fl_tag_b", 96'(fpu_tag_o), 96'd0);
      tick();
      flush_i = 1'b1;
      fpu_return(1'b1, 32'h0000_00dd, 5'b11111);
      #1;
      check_eq("fl_flush_o", 96'(fpu_flush_o), 96'd1);
      check_eq("fl_ready", 96'(req_ready_o), 96'd0);
      check_eq("fl_in_valid", 96'(fpu_in_valid_o), 96'd0);
      tick();
      flush_i     = 1'b0;
      req_valid_i = 1'b0;
      fpu_return(1'b0, 32'h0000_00ee, 5'b0);
      #1;
      check_eq("fl_busy", 96'(busy_o), 96'd0);
      check_eq("fl_rsp_valid", 96'(rsp_valid_o), 96'd0);
      check_eq("fl_perr_before", 96'(protocol_err_o), 96'd0);
      tick();
      fpu_out_valid_i = 1'b0;
      #1;
      check_eq("fl_perr_late", 96'(protocol_err_o), 96'd1);
      check_eq("fl_rsp_still_idle", 96'(rsp_valid_o), 96'd0);
      check_eq("fl_fflags_kept", 96'(fflags_o), 96'd0);

      // sticky flags accumulate, then clear beats a same-cycle retire
      req_valid_i = 1'b1;
      req_rd_i    = 5'd1;
      #1;
      tick();
      req_rd_i = 5'd2;
      #1;
      tick();
      req_valid_i = 1'b0;
      fpu_return(1'b0, 32'h0000_0001, 5'b00001);
      tick();
      fpu_return(1'b1, 32'h0000_0002, 5'b10000);
      tick();
      fpu_out_valid_i = 1'b0;
      rsp_ready_i     = 1'b1;
      #1;
      check_eq("fg_status0", 96'(rsp_status_o), 96'(5'b00001));
      check_eq("fg_pre", 96'(fflags_o), 96'd0);
      tick();
      check_eq("fg_after0", 96'(fflags_o), 96'(5'b00001));
      check_eq("fg_status1", 96'(rsp_status_o), 96'(5'b10000));
      tick();
      check_eq("fg_after1", 96'(fflags_o), 96'(5'b10001));
      check_eq("fg_busy", 96'(busy_o), 96'd0);
      rsp_ready_i = 1'b0;
      req_valid_i = 1'b1;
      req_rd_i    = 5'd3;
      #1;
      check_eq("fg_tag", 96'(fpu_tag_o), 96'd0);
      tick();
      req_valid_i = 1'b0;
      fpu_return(1'b0, 32'h0000_0003, 5'b00100);
      tick();
      fpu_out_valid_i = 1'b0;
      rsp_ready_i     = 1'b1;
      fflags_clr_i    = 1'b1;
      #1;
      check_eq("fg_clr_valid", 96'(rsp_valid_o), 96'd1);
      tick();
      fflags_clr_i = 1'b0;
      rsp_ready_i  = 1'b0;
      #1;
      check_eq("fg_clr_wins", 96'(fflags_o), 96'd0);
      check_eq("fg_clr_busy", 96'(busy_o), 96'd0);
      check_eq("perr_sticky", 96'(protocol_err_o), 96'd1);

      rst_ni = 1'b0;
      tick();
      rst_ni = 1'b1;
      #1;
      check_eq("perr_reset", 96'(protocol_err_o), 96'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
